mctrl: RTL and testbench
========================

MCTRL -- requirements
Module: mctrl

Interface
REQ-001 The block SHALL have no parameters; all encodings below are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 opcode  input  6  instr[31:26] from instruction register.
REQ-005 funct  input  6  instr[5:0] from instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 overflow  input  1  ALU signed-overflow flag.
REQ-008 PcWrite  output  1  PC load strobe.
REQ-009 IrWrite  output  1  instruction register load strobe.
REQ-010 RegWrite  output  1  GPR write strobe.
REQ-011 MemWrite  output  1  data memory write strobe.
REQ-012 RegDst  output  2  0=rt, 1=rd, 2=$31.
REQ-013 AluSrc  output  1  0=rd2, 1=extended immediate.
REQ-014 wd_sel  output  2  0=AluOut, 1=readdata, 2=pcp4.
REQ-015 NpcSel  output  3  0=PC+4, 1=beq target, 2=j/jal target, 3=register (jr).
REQ-016 ExtOp  output  2  0=zero-extend, 1=sign-extend, 2=load-upper.
REQ-017 AluCtrl  output  4  0=addu, 1=subu, 2=or, 3=slt, 4=add (overflow-checked).
REQ-018 lb  output  1  byte-load select for data memory.
REQ-019 state  output  4  current FSM state code, for debug.
REQ-020 instr_cnt  output  32  count of retired instructions.

Function
REQ-021 Supported instructions: R-type (opcode 000000) addu 100001, subu 100011, slt 101010, jr 001000; ori 001101, lui 001111, addi 001000, lw 100011, lb 100000, sw 101011, beq 000100, j 000010, jal 000011.
REQ-022 States and codes: FETCH=0, DECODE=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB_ALU=5, WB_MEM=6, BRANCH=7, JUMP=8; codes 9-15 unreachable and SHALL go to FETCH on the next edge.
REQ-023 FETCH: IrWrite=1, PcWrite=1, NpcSel=0; next DECODE.
REQ-024 DECODE: no strobes; next BRANCH for beq, JUMP for j/jal/jr, EXEC for all other supported opcodes, FETCH for unsupported opcode/funct (2-cycle no-op, not counted).
REQ-025 EXEC: AluSrc, ExtOp, AluCtrl driven per instruction; next MEM_RD for lw/lb, MEM_WR for sw, otherwise WB_ALU.
REQ-026 MEM_RD: address and lb held stable; next WB_MEM.  MEM_WR: MemWrite=1; next FETCH.
REQ-027 WB_ALU: RegWrite=1, wd_sel=0, RegDst=1 for R-type else 0; next FETCH.
REQ-028 addi in WB_ALU: RegWrite SHALL be 0 when overflow=1 (no GPR update); the instruction still retires.
REQ-029 WB_MEM: RegWrite=1, wd_sel=1, RegDst=0, lb=1 for lb opcode; next FETCH.
REQ-030 BRANCH: AluCtrl=1, AluSrc=0; PcWrite=zero, NpcSel=1; next FETCH.
REQ-031 JUMP: PcWrite=1, NpcSel=2 for j/jal, 3 for jr; jal also RegWrite=1, RegDst=2, wd_sel=2; next FETCH.
REQ-032 ALU/ext encodings SHALL be held identically from EXEC through the final state of each instruction so AluOut and overflow stay valid: ori ExtOp=0 AluCtrl=2; lui ExtOp=2 AluCtrl=2 (rs=$0); addi ExtOp=1 AluCtrl=4; lw/lb/sw ExtOp=1 AluCtrl=0.
REQ-033 Strobes (PcWrite, IrWrite, RegWrite, MemWrite) SHALL be 0 in every state not listed as asserting them.
REQ-034 Latency: arithmetic/logical 4 cycles, lw/lb 5, sw 4, beq/j/jal/jr 3.
REQ-035 instr_cnt SHALL increment by 1 on the edge leaving the final state of each supported instruction; wraps 0xFFFFFFFF to 0.

Reset
REQ-036 While rst=1: state=FETCH, instr_cnt=0, all strobes forced 0, multi-bit selects 0.
REQ-037 rst asserted mid-instruction SHALL abort it with no further strobe; first edge after release executes FETCH.

Verification
REQ-038 Reset release, opcode=ori -> states 0,1,2,5,0; RegWrite=1 only in state 5; instr_cnt=1.
REQ-039 lw then sw -> lw: 0,1,2,3,6 with wd_sel=1 in 6; sw: 0,1,2,4 with MemWrite=1 in 4; instr_cnt=2.
REQ-040 beq with zero=0 then zero=1 -> PcWrite=0 then 1 in state 7, NpcSel=1 both.
REQ-041 addi with overflow=1 -> RegWrite=0 in state 5, instr_cnt still +1; jal -> state 8 with RegDst=2, wd_sel=2, RegWrite=1.
REQ-042 Unsupported opcode 111111 -> 0,1,0 with no strobes after FETCH, instr_cnt unchanged; rst pulse in state 3 -> state=0, strobes 0 immediately.

Source files
------------

// File: rtl/mctrl.sv
// mctrl: multi-cycle control FSM for a MIPS subset, with a retired-instruction counter.
// Outputs decode from the current state and instruction fields; reset forces them all to 0.
module mctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        overflow,
  output logic        PcWrite,
  output logic        IrWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [1:0]  RegDst,
  output logic        AluSrc,
  output logic [1:0]  wd_sel,
  output logic [2:0]  NpcSel,
  output logic [1:0]  ExtOp,
  output logic [3:0]  AluCtrl,
  output logic        lb,
  output logic [3:0]  state,
  output logic [31:0] instr_cnt
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC = 4'd2, MEM_RD = 4'd3, MEM_WR = 4'd4,
    WB_ALU = 4'd5, WB_MEM = 4'd6, BRANCH = 4'd7, JUMP = 4'd8
  } state_t;
  state_t state_q, state_d;
  logic [31:0] cnt_q;
  logic rtype, r_addu, r_subu, r_slt, r_jr;
  logic i_ori, i_lui, i_addi, i_lw, i_lb, i_sw, i_beq, i_j, i_jal;
  logic is_exec, is_jump, retire;
  logic s_fetch, s_wb_alu, s_wb_mem, s_mem_wr, s_branch, s_jump, hold;
  assign rtype  = opcode == 6'h00;
  assign r_addu = rtype && funct == 6'h21;
  assign r_subu = rtype && funct == 6'h23;
  assign r_slt  = rtype && funct == 6'h2a;
  assign r_jr   = rtype && funct == 6'h08;
  assign i_ori  = opcode == 6'h0d;
  assign i_lui  = opcode == 6'h0f;
  assign i_addi = opcode == 6'h08;
  assign i_lw   = opcode == 6'h23;
  assign i_lb   = opcode == 6'h20;
  assign i_sw   = opcode == 6'h2b;
  assign i_beq  = opcode == 6'h04;
  assign i_j    = opcode == 6'h02;
  assign i_jal  = opcode == 6'h03;
  assign is_jump = i_j || i_jal || r_jr;
  assign is_exec = r_addu || r_subu || r_slt || i_ori || i_lui || i_addi || i_lw || i_lb || i_sw;
  assign retire  = state_q inside {MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP};
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: state_d = i_beq ? BRANCH : is_jump ? JUMP : is_exec ? EXEC : FETCH;
      EXEC:   state_d = (i_lw || i_lb) ? MEM_RD : i_sw ? MEM_WR : WB_ALU;
      MEM_RD: state_d = WB_MEM;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_q + {31'd0, retire};
    end
  end
  // Every state qualifier includes !rst so outputs drop to 0 the moment reset asserts.
  assign s_fetch  = !rst && state_q == FETCH;
  assign s_wb_alu = !rst && state_q == WB_ALU;
  assign s_wb_mem = !rst && state_q == WB_MEM;
  assign s_mem_wr = !rst && state_q == MEM_WR;
  assign s_branch = !rst && state_q == BRANCH;
  assign s_jump   = !rst && state_q == JUMP;
  assign hold     = !rst && state_q inside {EXEC, MEM_RD, MEM_WR, WB_ALU, WB_MEM};
  assign PcWrite  = s_fetch || (s_branch && zero) || s_jump;
  assign IrWrite  = s_fetch;
  assign RegWrite = (s_wb_alu && !(i_addi && overflow)) || s_wb_mem || (s_jump && i_jal);
  assign MemWrite = s_mem_wr;
  assign RegDst   = (s_wb_alu && rtype) ? 2'd1 : (s_jump && i_jal) ? 2'd2 : 2'd0;
  assign wd_sel   = s_wb_mem ? 2'd1 : (s_jump && i_jal) ? 2'd2 : 2'd0;
  assign NpcSel   = s_branch ? 3'd1 : s_jump ? (r_jr ? 3'd3 : 3'd2) : 3'd0;
  assign AluSrc   = hold && !rtype;
  assign ExtOp    = !hold || rtype || i_ori ? 2'd0 : i_lui ? 2'd2 : 2'd1;
  assign AluCtrl  = s_branch ? 4'd1 : !hold ? 4'd0 : r_subu ? 4'd1 :
                    (i_ori || i_lui) ? 4'd2 : r_slt ? 4'd3 : i_addi ? 4'd4 : 4'd0;
  assign lb        = hold && i_lb;
  assign state     = state_q;
  assign instr_cnt = cnt_q;
endmodule

// File: tb/tb_mctrl.sv
// tb_mctrl: table-driven per-cycle check of mctrl state, control bundle and instruction count,
// followed by an asynchronous reset pulse during a load's memory-read state.
module tb_mctrl;
  logic clk, rst, zero, overflow;
  logic [5:0] opcode, funct;
  logic PcWrite, IrWrite, RegWrite, MemWrite, AluSrc, lb;
  logic [1:0] RegDst, wd_sel, ExtOp;
  logic [2:0] NpcSel;
  logic [3:0] AluCtrl, state;
  logic [31:0] instr_cnt;
  int errors = 0, checks = 0;

  localparam logic [5:0] RT = 6'h00, ORI = 6'h0d, ADDI = 6'h08, LW = 6'h23, LB = 6'h20,
                         SW = 6'h2b, BEQ = 6'h04, JAL = 6'h03, BAD = 6'h3f;
  localparam logic [5:0] F_ADDU = 6'h21, F_SLT = 6'h2a, F_JR = 6'h08;

  typedef struct {
    logic        r, z, ov;
    logic [5:0]  op, fn;
    logic [3:0]  st;
    logic [31:0] cnt;
    logic [18:0] ctl;
  } vec_t;
  vec_t vecs[$];

  mctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
    .PcWrite(PcWrite), .IrWrite(IrWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .RegDst(RegDst), .AluSrc(AluSrc), .wd_sel(wd_sel), .NpcSel(NpcSel), .ExtOp(ExtOp),
    .AluCtrl(AluCtrl), .lb(lb), .state(state), .instr_cnt(instr_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [18:0] c(input logic pcw, irw, rw, mw, input logic [1:0] rd,
                                     input logic as, input logic [1:0] ws, input logic [2:0] ns,
                                     input logic [1:0] ex, input logic [3:0] ac, input logic l);
    return {pcw, irw, rw, mw, rd, as, ws, ns, ex, ac, l};
  endfunction

  function automatic logic [18:0] act();
    return {PcWrite, IrWrite, RegWrite, MemWrite, RegDst, AluSrc, wd_sel, NpcSel, ExtOp, AluCtrl, lb};
  endfunction

  task automatic add(input logic r, input logic [5:0] op, fn, input logic z, ov,
                     input logic [3:0] st, input logic [31:0] cnt, input logic [18:0] ctl);
    vec_t v;
    v.r = r; v.op = op; v.fn = fn; v.z = z; v.ov = ov; v.st = st; v.cnt = cnt; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] st, input logic [31:0] cnt,
                       input logic [18:0] ctl);
    checks += 3;
    if (state !== st) begin
      errors++;
      $display("FAIL %s state: got %0d want %0d", name, state, st);
    end
    if (act() !== ctl) begin
      errors++;
      $display("FAIL %s controls: got %b want %b", name, act(), ctl);
    end
    if (instr_cnt !== cnt) begin
      errors++;
      $display("FAIL %s instr_cnt: got %0d want %0d", name, instr_cnt, cnt);
    end
  endtask

  initial begin
    logic [18:0] fz, ff;
    fz = '0;
    ff = c(1,1,0,0,0,0,0,0,0,0,0);
    rst = 1; opcode = ORI; funct = 0; zero = 0; overflow = 0;
    add(1, ORI, 0, 0, 0, 0, 0, fz);
    add(0, ORI, 0, 0, 0, 0, 0, ff);
    add(0, ORI, 0, 0, 0, 1, 0, fz);
    add(0, ORI, 0, 0, 0, 2, 0, c(0,0,0,0,0,1,0,0,0,2,0));
    add(0, ORI, 0, 0, 0, 5, 0, c(0,0,1,0,0,1,0,0,0,2,0));
    add(0, LW, 0, 0, 0, 0, 1, ff);
    add(0, LW, 0, 0, 0, 1, 1, fz);
    add(0, LW, 0, 0, 0, 2, 1, c(0,0,0,0,0,1,0,0,1,0,0));
    add(0, LW, 0, 0, 0, 3, 1, c(0,0,0,0,0,1,0,0,1,0,0));
    add(0, LW, 0, 0, 0, 6, 1, c(0,0,1,0,0,1,1,0,1,0,0));
    add(0, SW, 0, 0, 0, 0, 2, ff);
    add(0, SW, 0, 0, 0, 1, 2, fz);
    add(0, SW, 0, 0, 0, 2, 2, c(0,0,0,0,0,1,0,0,1,0,0));
    add(0, SW, 0, 0, 0, 4, 2, c(0,0,0,1,0,1,0,0,1,0,0));
    add(0, BEQ, 0, 0, 0, 0, 3, ff);
    add(0, BEQ, 0, 0, 0, 1, 3, fz);
    add(0, BEQ, 0, 0, 0, 7, 3, c(0,0,0,0,0,0,0,1,0,1,0));
    add(0, BEQ, 0, 1, 0, 0, 4, ff);
    add(0, BEQ, 0, 1, 0, 1, 4, fz);
    add(0, BEQ, 0, 1, 0, 7, 4, c(1,0,0,0,0,0,0,1,0,1,0));
    add(0, ADDI, 0, 0, 1, 0, 5, ff);
    add(0, ADDI, 0, 0, 1, 1, 5, fz);
    add(0, ADDI, 0, 0, 1, 2, 5, c(0,0,0,0,0,1,0,0,1,4,0));
    add(0, ADDI, 0, 0, 1, 5, 5, c(0,0,0,0,0,1,0,0,1,4,0));
    add(0, JAL, 0, 0, 0, 0, 6, ff);
    add(0, JAL, 0, 0, 0, 1, 6, fz);
    add(0, JAL, 0, 0, 0, 8, 6, c(1,0,1,0,2,0,2,2,0,0,0));
    add(0, BAD, 0, 0, 0, 0, 7, ff);
    add(0, BAD, 0, 0, 0, 1, 7, fz);
    add(0, BAD, 0, 0, 0, 0, 7, ff);
    add(0, RT, F_ADDU, 0, 0, 1, 7, fz);
    add(0, RT, F_ADDU, 0, 0, 2, 7, fz);
    add(0, RT, F_ADDU, 0, 0, 5, 7, c(0,0,1,0,1,0,0,0,0,0,0));
    add(0, RT, F_JR, 0, 0, 0, 8, ff);
    add(0, RT, F_JR, 0, 0, 1, 8, fz);
    add(0, RT, F_JR, 0, 0, 8, 8, c(1,0,0,0,0,0,0,3,0,0,0));
    add(0, RT, F_SLT, 0, 0, 0, 9, ff);
    add(0, RT, F_SLT, 0, 0, 1, 9, fz);
    add(0, RT, F_SLT, 0, 0, 2, 9, c(0,0,0,0,0,0,0,0,0,3,0));
    add(0, RT, F_SLT, 0, 0, 5, 9, c(0,0,1,0,1,0,0,0,0,3,0));
    add(0, LB, 0, 0, 0, 0, 10, ff);
    add(0, LB, 0, 0, 0, 1, 10, fz);
    add(0, LB, 0, 0, 0, 2, 10, c(0,0,0,0,0,1,0,0,1,0,1));
    add(0, LB, 0, 0, 0, 3, 10, c(0,0,0,0,0,1,0,0,1,0,1));
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].r; opcode = vecs[i].op; funct = vecs[i].fn;
      zero = vecs[i].z; overflow = vecs[i].ov;
      #1 check($sformatf("vec%0d", i), vecs[i].st, vecs[i].cnt, vecs[i].ctl);
    end
    #1 rst = 1;
    #1 check("async_rst_mem_rd", 0, 0, fz);
    @(negedge clk);
    #1 check("held_rst", 0, 0, fz);
    rst = 0;
    #1 check("post_rst_fetch", 0, 0, ff);
    @(negedge clk);
    #1 check("post_rst_decode", 1, 0, fz);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
